// File: rtl/sseg_scan_mux_if.sv
// sseg_scan_mux_if: BCD result input and multiplexed seven-segment output bundle
interface sseg_scan_mux_if;
    logic       sign;
    logic [3:0] hundred;
    logic [3:0] tens;
    logic [3:0] unit;
    logic       load;
    logic       pending;
    logic [3:0] an;
    logic [7:0] sseg;
    modport master (output sign, hundred, tens, unit, load, input pending, an, sseg);
    modport slave (input sign, hundred, tens, unit, load, output pending, an, sseg);
endinterface

// File: rtl/sseg_scan_mux.sv
// sseg_scan_mux: 4-digit scanned seven-segment driver, frame-synchronous updates, leading-zero blanking
module sseg_scan_mux #(
    parameter int DIV   = 100000,
    parameter int CNT_W = 20
) (
    input logic            clk,
    input logic            reset,
    sseg_scan_mux_if.slave bus
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [12:0]      stg_q, stg_d, act_q, act_d, in_w;
    logic             pend_q, pend_d;
    logic [3:0]       an_q, an_d;
    logic [7:0]       sseg_q, sseg_d;
    logic             tick, bnd, hz, tz, neg;
    logic [6:0]       code;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    always_comb begin
        in_w   = {bus.sign, bus.hundred, bus.tens, bus.unit};
        tick   = cnt_q == CNT_W'(DIV - 1);
        bnd    = tick && idx_q == 2'd3;
        cnt_d  = tick ? '0 : cnt_q + 1'b1;
        idx_d  = idx_q + {1'b0, tick};
        stg_d  = bus.load ? in_w : stg_q;
        // a load coinciding with the frame boundary bypasses staging
        act_d  = bnd && bus.load ? in_w : bnd && pend_q ? stg_q : act_q;
        pend_d = !bnd && (bus.load || pend_q);
        hz     = act_q[11:8] == 4'd0;
        tz     = hz && act_q[7:4] == 4'd0;
        neg    = act_q[12] && act_q[11:0] != 12'd0;
        code   = idx_q == 2'd0 ? seg7(act_q[3:0]) :
                 idx_q == 2'd1 ? (tz ? 7'h7F : seg7(act_q[7:4])) :
                 idx_q == 2'd2 ? (hz ? 7'h7F : seg7(act_q[11:8])) :
                 (neg ? 7'h3F : 7'h7F);
        an_d   = ~(4'b0001 << idx_q);
        sseg_d = {1'b1, code};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            stg_q  <= '0;
            act_q  <= '0;
            pend_q <= 1'b0;
            an_q   <= 4'hF;
            sseg_q <= 8'hFF;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            stg_q  <= stg_d;
            act_q  <= act_d;
            pend_q <= pend_d;
            an_q   <= an_d;
            sseg_q <= sseg_d;
        end
    end

    assign bus.pending = pend_q;
    assign bus.an      = an_q;
    assign bus.sseg    = sseg_q;
endmodule

// File: tb/tb_sseg_scan_mux.sv
// tb_sseg_scan_mux: randomized and directed checks of the scan driver against a frame-level model
module tb_sseg_scan_mux;
    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic clk = 1'b0;
    logic reset = 1'b1;
    sseg_scan_mux_if bus ();

    sseg_scan_mux #(.DIV(DIV), .CNT_W(3)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          t = 0;
    logic [12:0] act = '0;
    logic [12:0] stg = '0;
    logic        pend = 1'b0;
    logic [6:0]  tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got=%h want=%h", tag, t, obs, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] d);
        return d < 4'd10 ? tbl[d] : 7'h7F;
    endfunction

    // display position 0..3 = units, tens, hundreds, sign
    function automatic logic [6:0] shown(input int pos, input logic [12:0] a);
        case (pos)
            0:       return glyph(a[3:0]);
            1:       return a[11:4] == 8'd0 ? 7'h7F : glyph(a[7:4]);
            2:       return a[11:8] == 4'd0 ? 7'h7F : glyph(a[11:8]);
            default: return a[12] && a[11:0] != 12'd0 ? 7'h3F : 7'h7F;
        endcase
    endfunction

    task automatic step(input logic ld, input logic [12:0] v);
        int         pos;
        logic       bnd;
        logic [3:0] e_an;
        logic [7:0] e_seg;
        reset = 1'b0;
        bus.load = ld;
        {bus.sign, bus.hundred, bus.tens, bus.unit} = v;
        pos   = (t / DIV) % 4;
        bnd   = (t % FRAME) == FRAME - 1;
        e_an  = 4'b1111 ^ (4'b0001 << pos);
        e_seg = {1'b1, shown(pos, act)};
        if (ld) stg = v;
        if (bnd) begin
            if (ld) act = v;
            else if (pend) act = stg;
            pend = 1'b0;
        end else if (ld) pend = 1'b1;
        t++;
        @(posedge clk);
        #1;
        chk("an", 32'(bus.an), 32'(e_an));
        chk("sseg", 32'(bus.sseg), 32'(e_seg));
        chk("pending", 32'(bus.pending), 32'(pend));
        bus.load = 1'b0;
    endtask

    task automatic rst();
        reset = 1'b1;
        bus.load = 1'b0;
        @(posedge clk);
        #1;
        t = 0;
        act = '0;
        stg = '0;
        pend = 1'b0;
        chk("rst_an", 32'(bus.an), 32'hF);
        chk("rst_sseg", 32'(bus.sseg), 32'hFF);
        chk("rst_pending", 32'(bus.pending), 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 13'h0);
    endtask

    task automatic to_phase(input int ph);
        for (int i = 0; i < FRAME && (t % FRAME) != ph; i++) step(1'b0, 13'h0);
    endtask

    function automatic logic [3:0] rdig();
        return ($urandom % 4 == 0) ? 4'd0 : 4'($urandom_range(0, 11));
    endfunction

    initial begin
        bus.load = 1'b0;
        {bus.sign, bus.hundred, bus.tens, bus.unit} = '0;
        @(posedge clk);
        #1;
        rst();
        idle(FRAME);
        to_phase(5);
        step(1'b1, {1'b1, 4'd1, 4'd2, 4'd7});
        idle(2 * FRAME);
        step(1'b1, {1'b0, 4'd0, 4'd0, 4'd5});
        idle(FRAME + 4);
        step(1'b1, {1'b0, 4'd0, 4'd4, 4'd0});
        idle(2 * FRAME);
        to_phase(2);
        step(1'b1, {1'b0, 4'd0, 4'd0, 4'd8});
        idle(3);
        step(1'b1, {1'b0, 4'd2, 4'd5, 4'd5});
        idle(2 * FRAME);
        to_phase(FRAME - 1);
        step(1'b1, {1'b0, 4'd0, 4'd9, 4'd9});
        idle(2 * FRAME);
        step(1'b1, {1'b1, 4'd0, 4'd0, 4'd0});
        idle(2 * FRAME);
        to_phase(6);
        step(1'b1, {1'b0, 4'd3, 4'd4, 4'd5});
        idle(2);
        rst();
        idle(2 * FRAME);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom % 16 == 0) step(1'b1, {1'($urandom), rdig(), rdig(), rdig()});
            else step(1'b0, 13'($urandom));
            if (i % 500 == 499) rst();
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
